// File: rtl/risc_controller_if.sv
`default_nettype none
// ============================================================================
// Module      : risc_controller_if
// Description : Bundle of the sequencer's opcode/flag inputs and control
//               strobe outputs. The controller uses the master view, the
//               datapath (or a bench) uses the slave view.
// Revision    : 1.0 - initial release
// ============================================================================
interface risc_controller_if #(
    parameter int OP_WIDTH = 3
);
    logic [OP_WIDTH-1:0] opcode;
    logic                zero;
    logic                sel;
    logic                rd;
    logic                wr;
    logic                ld_ir;
    logic                ld_ac;
    logic                inc_pc;
    logic                ld_pc;
    logic                data_e;
    logic                halt;
    logic [2:0]          phase;

    modport master (
        input  opcode, zero,
        output sel, rd, wr, ld_ir, ld_ac, inc_pc, ld_pc, data_e, halt, phase
    );

    modport slave (
        output opcode, zero,
        input  sel, rd, wr, ld_ir, ld_ac, inc_pc, ld_pc, data_e, halt, phase
    );
endinterface
`default_nettype wire

// File: rtl/risc_controller.sv
`default_nettype none
// ============================================================================
// Module      : risc_controller
// Description : 8-phase instruction sequencer for the RISC-Y CPU. Steps each
//               instruction through fetch, decode and execute phases and
//               decodes the control strobes from the current phase, opcode,
//               zero flag and halted flag. Stops on HLT until reset.
// Revision    : 1.0 - initial release
// ============================================================================
module risc_controller #(
    parameter int OP_WIDTH = 3
) (
    input  wire logic         clk,
    input  wire logic         rst,
    risc_controller_if.master bus
);

    typedef enum logic [2:0] {
        PH_INST_ADDR  = 3'd0,
        PH_INST_FETCH = 3'd1,
        PH_INST_LOAD  = 3'd2,
        PH_IDLE       = 3'd3,
        PH_OP_ADDR    = 3'd4,
        PH_OP_FETCH   = 3'd5,
        PH_ALU_OP     = 3'd6,
        PH_STORE      = 3'd7
    } phase_t;

    localparam logic [OP_WIDTH-1:0] C_OP_HLT = OP_WIDTH'(0);
    localparam logic [OP_WIDTH-1:0] C_OP_SKZ = OP_WIDTH'(1);
    localparam logic [OP_WIDTH-1:0] C_OP_ADD = OP_WIDTH'(2);
    localparam logic [OP_WIDTH-1:0] C_OP_AND = OP_WIDTH'(3);
    localparam logic [OP_WIDTH-1:0] C_OP_XOR = OP_WIDTH'(4);
    localparam logic [OP_WIDTH-1:0] C_OP_LDA = OP_WIDTH'(5);
    localparam logic [OP_WIDTH-1:0] C_OP_STO = OP_WIDTH'(6);
    localparam logic [OP_WIDTH-1:0] C_OP_JMP = OP_WIDTH'(7);

    phase_t r_phase;
    logic   r_halted;

    logic w_is_hlt;
    logic w_is_skz;
    logic w_is_sto;
    logic w_is_jmp;
    logic w_is_aluop;

    logic w_sel;
    logic w_rd;
    logic w_wr;
    logic w_ld_ir;
    logic w_ld_ac;
    logic w_inc_pc;
    logic w_ld_pc;
    logic w_data_e;
    logic w_halt;

    // Opcode class decode; only meaningful from the IDLE phase onward.
    assign w_is_hlt   = (bus.opcode == C_OP_HLT);
    assign w_is_skz   = (bus.opcode == C_OP_SKZ);
    assign w_is_sto   = (bus.opcode == C_OP_STO);
    assign w_is_jmp   = (bus.opcode == C_OP_JMP);
    assign w_is_aluop = (bus.opcode == C_OP_ADD) || (bus.opcode == C_OP_AND) ||
                        (bus.opcode == C_OP_XOR) || (bus.opcode == C_OP_LDA);

    // Phase counter and halted flag; reset beats halt, halt freezes phase at 4.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_phase  <= PH_INST_ADDR;
            r_halted <= 1'b0;
        end else if (r_halted) begin
            r_phase  <= r_phase;
            r_halted <= 1'b1;
        end else if ((r_phase == PH_OP_ADDR) && w_is_hlt) begin
            r_phase  <= PH_OP_ADDR;
            r_halted <= 1'b1;
        end else begin
            r_phase  <= phase_t'(r_phase + 3'd1);
        end
    end

    // Strobe decode from phase, opcode, zero flag and halted flag.
    always_comb begin
        w_sel    = 1'b0;
        w_rd     = 1'b0;
        w_wr     = 1'b0;
        w_ld_ir  = 1'b0;
        w_ld_ac  = 1'b0;
        w_inc_pc = 1'b0;
        w_ld_pc  = 1'b0;
        w_data_e = 1'b0;
        w_halt   = 1'b0;
        if (r_halted) begin
            // Only HALT is asserted so the PC and memory stay frozen.
            w_halt = 1'b1;
        end else begin
            case (r_phase)
                PH_INST_ADDR: begin
                    w_sel = 1'b1;
                end
                PH_INST_FETCH: begin
                    w_sel = 1'b1;
                    w_rd  = 1'b1;
                end
                PH_INST_LOAD, PH_IDLE: begin
                    w_sel   = 1'b1;
                    w_rd    = 1'b1;
                    w_ld_ir = 1'b1;
                end
                PH_OP_ADDR: begin
                    w_inc_pc = ~w_is_hlt;
                    w_halt   = w_is_hlt;
                end
                PH_OP_FETCH: begin
                    w_rd = w_is_aluop;
                end
                PH_ALU_OP: begin
                    w_rd     = w_is_aluop;
                    w_inc_pc = w_is_skz & bus.zero;
                    w_ld_pc  = w_is_jmp;
                    w_data_e = w_is_sto;
                end
                PH_STORE: begin
                    w_rd     = w_is_aluop;
                    w_ld_ac  = w_is_aluop;
                    w_inc_pc = w_is_jmp;
                    w_ld_pc  = w_is_jmp;
                    w_wr     = w_is_sto;
                    w_data_e = w_is_sto;
                end
                default: begin
                    w_sel = 1'b0;
                end
            endcase
        end
    end

    assign bus.sel    = w_sel;
    assign bus.rd     = w_rd;
    assign bus.wr     = w_wr;
    assign bus.ld_ir  = w_ld_ir;
    assign bus.ld_ac  = w_ld_ac;
    assign bus.inc_pc = w_inc_pc;
    assign bus.ld_pc  = w_ld_pc;
    assign bus.data_e = w_data_e;
    assign bus.halt   = w_halt;
    assign bus.phase  = r_phase;

endmodule
`default_nettype wire
